// File: rtl/des_link_pkg.sv
// Shared definitions for the secure-link word packers.
// Holds the receive deframer state set, the default frame start marker and
// the number of 16-bit link words that make up one 64-bit block (also used
// by the transmit-side packer).
package des_link_pkg;

    localparam int unsigned WORDS_PER_64      = 4;
    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_KEY    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHK    = 3'd3,
        ST_LAUNCH = 3'd4,
        ST_WAIT   = 3'd5,
        ST_OUT    = 3'd6,
        ST_DONE   = 3'd7
    } deframe_state_e;

endpackage

// File: rtl/word_ser64.sv
// 64-bit to 16-bit serialiser.
// A load captures a 64-bit block; the block then leaves as four consecutive
// 16-bit words, most significant word first, with no backpressure.
// Ports:
//   clk, rst       clock and asynchronous active-low reset
//   load           capture load_data this cycle (starts a new burst)
//   load_data      64-bit block to serialise
//   word           current output word (zero when idle)
//   valid          word is valid
//   last           word is the final word of the burst
module word_ser64
    import des_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_data,
    output logic [15:0] word,
    output logic        valid,
    output logic        last
);

    logic [63:0] shift_reg;
    logic [1:0]  word_cnt;
    logic        active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            word_cnt  <= '0;
            active    <= 1'b0;
        end else if (load) begin
            shift_reg <= load_data;
            word_cnt  <= '0;
            active    <= 1'b1;
        end else if (active) begin
            // zeros shift in, so the register is empty again after a burst
            shift_reg <= {shift_reg[47:0], 16'h0000};
            word_cnt  <= word_cnt + 2'd1;
            if (word_cnt == 2'(WORDS_PER_64 - 1))
                active <= 1'b0;
        end
    end

    assign word  = shift_reg[63:48];
    assign valid = active;
    assign last  = active && (word_cnt == 2'(WORDS_PER_64 - 1));

endmodule

// File: rtl/des_rx_deframer.sv
// Receive-side deframer for the secure link.
// Hunts for SYNC_WORD, collects a 64-bit key and 64-bit ciphertext from
// 16-bit words, checks an XOR checksum, launches the des core in decrypt
// mode, waits for its ready edge, then emits the plaintext as four words.
//
//  state  | meaning
//  HUNT   | waiting for SYNC_WORD, other words dropped
//  KEY    | collecting 4 key words
//  DATA   | collecting 4 ciphertext words
//  CHK    | comparing checksum word with accumulator
//  LAUNCH | one-cycle des start pulse
//  WAIT   | waiting for des_ready_i rising edge or timeout
//  OUT    | four plaintext words on out_word
//  DONE   | one-cycle done pulse
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_word/in_ready link word input
//   key_o, data_o            assembled key and ciphertext to des
//   des_enable_o, des_mode_o des start pulse and decrypt mode
//   des_data_i, des_ready_i  des result and its ready level
//   out_word, out_valid      plaintext words, MSW first
//   done, err                completion / failure pulses
module des_rx_deframer
    import des_link_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_word,
    output logic        in_ready,
    output logic [63:0] key_o,
    output logic [63:0] data_o,
    output logic        des_enable_o,
    output logic        des_mode_o,
    input  logic [63:0] des_data_i,
    input  logic        des_ready_i,
    output logic [15:0] out_word,
    output logic        out_valid,
    output logic        done,
    output logic        err
);

    deframe_state_e state;
    logic [1:0]     word_cnt;
    logic [15:0]    acc;
    logic [15:0]    tmo_cnt;
    logic [15:0]    tmo_cnt_nxt;
    logic           ready_q;
    logic           ready_rise;
    logic           xfer;
    logic           last_word;
    logic           ser_load;
    logic           ser_last;

    assign in_ready    = (state == ST_HUNT) || (state == ST_KEY) ||
                         (state == ST_DATA) || (state == ST_CHK);
    assign xfer        = in_valid && in_ready;
    assign last_word   = (word_cnt == 2'(WORDS_PER_64 - 1));
    assign tmo_cnt_nxt = tmo_cnt + 16'd1;
    // ready_q follows des_ready_i every cycle, so a level already high when
    // WAIT is entered never looks like an edge
    assign ready_rise  = des_ready_i && !ready_q;
    assign ser_load    = (state == ST_WAIT) && ready_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_HUNT;
            key_o        <= '0;
            data_o       <= '0;
            des_enable_o <= 1'b0;
            des_mode_o   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            word_cnt     <= '0;
            acc          <= '0;
            tmo_cnt      <= '0;
            ready_q      <= 1'b0;
        end else begin
            ready_q      <= des_ready_i;
            des_enable_o <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (xfer && (in_word == SYNC_WORD)) begin
                        acc      <= '0;
                        word_cnt <= '0;
                        state    <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    if (xfer) begin
                        key_o    <= {key_o[47:0], in_word};
                        acc      <= acc ^ in_word;
                        word_cnt <= word_cnt + 2'd1;
                        if (last_word)
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        data_o   <= {data_o[47:0], in_word};
                        acc      <= acc ^ in_word;
                        word_cnt <= word_cnt + 2'd1;
                        if (last_word)
                            state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        if (in_word == acc) begin
                            des_enable_o <= 1'b1;
                            des_mode_o   <= 1'b1;
                            state        <= ST_LAUNCH;
                        end else begin
                            err   <= 1'b1;
                            state <= ST_HUNT;
                        end
                    end
                end
                ST_LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt_nxt;
                    // edge is tested first so it wins over a same-cycle timeout
                    if (ready_rise) begin
                        des_mode_o <= 1'b0;
                        state      <= ST_OUT;
                    end else if (tmo_cnt_nxt == 16'(TIMEOUT)) begin
                        err        <= 1'b1;
                        des_mode_o <= 1'b0;
                        state      <= ST_HUNT;
                    end
                end
                ST_OUT: begin
                    if (ser_last) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_HUNT;
                default: state <= ST_HUNT;
            endcase
        end
    end

    word_ser64 u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (des_data_i),
        .word      (out_word),
        .valid     (out_valid),
        .last      (ser_last)
    );

endmodule

// File: tb/tb_des_rx_deframer.sv
// Self-checking bench for des_rx_deframer. The bench plays the link
// transmitter and the des core; expected values come from the frame
// contents (XOR of payload words, word slices of the plaintext).
module tb_des_rx_deframer;

    localparam logic [15:0] SYNC = 16'hA55A;
    localparam int          TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_word = '0;
    logic        in_ready;
    logic [63:0] key_o;
    logic [63:0] data_o;
    logic        des_enable_o;
    logic        des_mode_o;
    logic [63:0] des_data_i = '0;
    logic        des_ready_i = 1'b0;
    logic [15:0] out_word;
    logic        out_valid;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    des_rx_deframer #(.SYNC_WORD(SYNC), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_word      (in_word),
        .in_ready     (in_ready),
        .key_o        (key_o),
        .data_o       (data_o),
        .des_enable_o (des_enable_o),
        .des_mode_o   (des_mode_o),
        .des_data_i   (des_data_i),
        .des_ready_i  (des_ready_i),
        .out_word     (out_word),
        .out_valid    (out_valid),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // checksum is the XOR of the eight payload words
    function automatic logic [15:0] xsum(input logic [63:0] k, input logic [63:0] c);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s = s ^ k[16*i +: 16] ^ c[16*i +: 16];
        return s;
    endfunction

    always @(negedge clk) if (rst) check("done_err_excl", done & err, 1'b0);

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // called at a negedge; the word is transferred at the next posedge
    task automatic send_word(input logic [15:0] w, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) @(negedge clk);
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 16'($urandom);
    endtask

    task automatic send_frame(input logic [63:0] k, input logic [63:0] c,
                              input logic [15:0] cs, input int max_gap);
        send_word(SYNC, max_gap);
        for (int i = 0; i < 4; i++) send_word(k[63-16*i -: 16], max_gap);
        for (int i = 0; i < 4; i++) send_word(c[63-16*i -: 16], max_gap);
        send_word(cs, max_gap);
    endtask

    // entered in the LAUNCH cycle; d = extra WAIT cycles before ready rises
    task automatic respond(input logic [63:0] pt, input int d, input bit stale);
        @(negedge clk);
        check("enable_one_pulse", des_enable_o, 1'b0);
        check("in_ready_wait", in_ready, 1'b0);
        if (stale) begin
            check("stale_ignored", out_valid, 1'b0);
            @(negedge clk);
            check("stale_ignored", out_valid, 1'b0);
            des_ready_i = 1'b0;
        end
        repeat (d) @(negedge clk);
        check("mode_wait", des_mode_o, 1'b1);
        check("no_early_out", out_valid, 1'b0);
        des_data_i  = pt;
        des_ready_i = 1'b1;
        @(negedge clk);
        check("mode_clear", des_mode_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            des_data_i = {32'($urandom), 32'($urandom)};
            check("out_valid", out_valid, 1'b1);
            check("out_word", out_word, pt[63-16*i -: 16]);
            check("done_early", done, 1'b0);
            check("in_ready_out", in_ready, 1'b0);
            @(negedge clk);
        end
        check("done_pulse", done, 1'b1);
        check("out_valid_off", out_valid, 1'b0);
        des_ready_i = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("back_to_hunt", in_ready, 1'b1);
    endtask

    task automatic run_frame(input logic [63:0] k, input logic [63:0] c, input logic [15:0] bad,
                             input int max_gap, input logic [63:0] pt, input int d, input bit stale);
        if (stale) des_ready_i = 1'b1;
        send_frame(k, c, xsum(k, c) ^ bad, max_gap);
        if (bad != 16'h0) begin
            check("bad_err", err, 1'b1);
            check("bad_no_enable", des_enable_o, 1'b0);
            @(negedge clk);
            check("bad_err_one_cycle", err, 1'b0);
            check("bad_hunt", in_ready, 1'b1);
            check("bad_mode", des_mode_o, 1'b0);
            des_ready_i = 1'b0;
        end else begin
            check("launch_enable", des_enable_o, 1'b1);
            check("launch_mode", des_mode_o, 1'b1);
            check("key_o", key_o, k);
            check("data_o", data_o, c);
            respond(pt, d, stale);
        end
    endtask

    localparam logic [63:0] K0 = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] C0 = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;

    initial begin
        logic [63:0] k, c, p;
        logic [15:0] bad, g;

        repeat (3) @(negedge clk);
        check("rst_key", key_o, 64'h0);
        check("rst_data", data_o, 64'h0);
        check("rst_enable", des_enable_o, 1'b0);
        check("rst_mode", des_mode_o, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_word", out_word, 16'h0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("hunt_ready", in_ready, 1'b1);

        // good frame
        run_frame(K0, C0, 16'h0, 0, P0, 2, 1'b0);
        // a checksum one bit off from the true XOR
        run_frame(K0, C0, 16'h0001, 0, P0, 0, 1'b0);
        run_frame(K0, C0, 16'h0, 0, P0, 1, 1'b0);
        // garbage before sync
        send_word(16'h1111, 0);
        send_word(16'hFFFF, 0);
        run_frame(K0, C0, 16'h0, 0, P0, 3, 1'b0);
        // gaps between payload words
        run_frame(K0, C0, 16'h0, 3, P0, 0, 1'b0);
        // sync word used as payload
        run_frame(64'hA55A_0001_A55A_0002, 64'h0003_A55A_0004_0005, 16'h0, 0, P0, 2, 1'b0);
        // ready edge in the same cycle the timeout would fire
        run_frame(K0, C0, 16'h0, 0, 64'hFEDC_BA98_7654_3210, TMO - 1, 1'b0);
        // stale ready level
        run_frame(K0, C0, 16'h0, 0, P0, 1, 1'b1);

        // timeout: ready never rises
        send_frame(K0, C0, xsum(K0, C0), 0);
        check("tmo_launch", des_enable_o, 1'b1);
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            check("tmo_no_err_yet", err, 1'b0);
            check("tmo_no_out", out_valid, 1'b0);
        end
        @(negedge clk);
        check("tmo_err", err, 1'b1);
        check("tmo_mode", des_mode_o, 1'b0);
        check("tmo_no_out", out_valid, 1'b0);
        @(negedge clk);
        check("tmo_err_one_cycle", err, 1'b0);
        check("tmo_hunt", in_ready, 1'b1);

        // reset in the middle of DATA
        send_word(SYNC, 0);
        for (int i = 0; i < 4; i++) send_word(K0[63-16*i -: 16], 0);
        send_word(C0[63:48], 0);
        send_word(C0[47:32], 0);
        rst = 1'b0;
        #1;
        check("mrst_key", key_o, 64'h0);
        check("mrst_data", data_o, 64'h0);
        check("mrst_mode", des_mode_o, 1'b0);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_err_after", err, 1'b0);
        check("mrst_hunt", in_ready, 1'b1);
        run_frame(K0, C0, 16'h0, 0, P0, 1, 1'b0);

        // randomized frames
        for (int n = 0; n < 20; n++) begin
            k = {32'($urandom), 32'($urandom)};
            c = {32'($urandom), 32'($urandom)};
            p = {32'($urandom), 32'($urandom)};
            bad = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(16'hFFFF, 1)) : 16'h0;
            repeat ($urandom_range(2, 0)) begin
                g = 16'($urandom);
                if (g == SYNC) g = ~g;
                send_word(g, 0);
            end
            run_frame(k, c, bad, int'($urandom_range(2, 0)), p,
                      int'($urandom_range(5, 0)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
